// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and FSM encoding for the
// instruction-fetch responder.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int CNT_W   = 4;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_WAIT = 2'd1;
  localparam state_t S_RESP = 2'd2;
  localparam state_t S_PF   = 2'd3;

endpackage

// File: rtl/imem_array.sv
// imem_array: DEPTH x DATA_W instruction store, one registered
// read port and one write port, read-before-write on collision.
module imem_array #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = fetch_pkg::INSTR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Program-load write port; contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read; sees the pre-write word on a same-edge write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/imem_responder.sv
// imem_responder: fetch-port memory with WAIT_STATES latency.
// Optional IMEM_PREFETCH_EN adds a next-line prefetch.
module imem_responder #(
  parameter int ADDR_W      = 6,
  parameter int INSTR_W     = fetch_pkg::INSTR_W,
  parameter int WAIT_STATES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en,
  input  logic               req_valid,
  input  logic [ADDR_W-1:0]  req_addr,
  output logic               req_ready,
  output logic [INSTR_W-1:0] read_data,
  output logic               data_ready,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [INSTR_W-1:0] wr_data
);

  import fetch_pkg::*;

  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;
  localparam bit NO_WAIT = (WAIT_STATES == 0);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  cap_addr;
  logic               accept;
  logic               cap;
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;
  logic [INSTR_W-1:0] rd_q;
  logic               wr_go;
  logic               pf_hit;
  logic               pf_rd;

  assign req_ready  = (state != S_WAIT);
  assign accept     = req_valid & req_ready & clk_en;
  assign data_ready = (state == S_RESP);
  assign wr_go      = wr_en & clk_en;

  assign cap = (accept & NO_WAIT & ~pf_hit)
             | (clk_en & (state == S_WAIT) & (cnt == '0));
  assign rd_en = cap | pf_rd;

`ifdef IMEM_PREFETCH_EN
  localparam state_t RESP_EXIT = S_PF;

  logic [ADDR_W-1:0]  pf_addr;
  logic [CNT_W-1:0]   pf_cnt;
  logic               pf_busy;
  logic               pf_valid;
  logic               out_sel;
  logic [INSTR_W-1:0] hold_q;

  assign pf_hit = (state == S_PF) & pf_valid
                & (req_addr == pf_addr);
  assign pf_rd = clk_en & (state == S_PF) & ~accept
               & pf_busy & (pf_cnt <= CNT_W'(1));
  assign rd_addr = pf_rd ? pf_addr
                 : (state == S_WAIT) ? cap_addr : req_addr;
  assign read_data = out_sel ? rd_q : hold_q;

  // Prefetch owns rd_q while in PF; the last response is
  // parked in hold_q so read_data never moves between strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pf_addr  <= '0;
      pf_cnt   <= '0;
      pf_busy  <= 1'b0;
      pf_valid <= 1'b0;
      hold_q   <= '0;
      out_sel  <= 1'b1;
    end else if (clk_en) begin
      if (accept) begin
        pf_busy  <= 1'b0;
        pf_valid <= 1'b0;
        if (pf_hit) out_sel <= 1'b1;
      end else if (state == S_RESP) begin
        pf_addr  <= cap_addr + 1'b1;
        pf_cnt   <= CNT_W'(WAIT_STATES);
        pf_busy  <= 1'b1;
        pf_valid <= 1'b0;
      end else if (pf_rd) begin
        pf_busy  <= 1'b0;
        pf_valid <= 1'b1;
        if (out_sel) hold_q <= rd_q;
        out_sel  <= 1'b0;
      end else if (pf_busy) begin
        pf_cnt <= pf_cnt - 1'b1;
      end
      if (cap) out_sel <= 1'b1;
      if (wr_go && (wr_addr == pf_addr)) pf_valid <= 1'b0;
    end
  end
`else
  localparam state_t RESP_EXIT = S_IDLE;

  assign pf_hit    = 1'b0;
  assign pf_rd     = 1'b0;
  assign rd_addr   = (state == S_WAIT) ? cap_addr : req_addr;
  assign read_data = rd_q;
`endif

  // Fetch FSM: accept, count wait states, one-cycle response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      cap_addr <= '0;
    end else if (clk_en) begin
      if (accept) begin
        cap_addr <= req_addr;
        if (NO_WAIT || pf_hit) begin
          state <= S_RESP;
        end else begin
          state <= S_WAIT;
          cnt   <= CNT_INIT;
        end
      end else begin
        unique case (1'b1)
          (state == S_WAIT): begin
            if (cnt == '0) state <= S_RESP;
            else cnt <= cnt - 1'b1;
          end
          (state == S_RESP): state <= RESP_EXIT;
          default: ;
        endcase
      end
    end
  end

  imem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (INSTR_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_q),
    .wr_en   (wr_go),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
Instruction-memory responder serving the core's fetch port, the memory side of the fetch request/response handshake.
- Holds a DEPTH-word instruction store, loaded through a separate write (program-load) port.
- Answers each accepted fetch after a programmable number of wait states, so the core's fetch stalls can be exercised against realistic memory latency.
- Sits between the core/l1 fetch logic and the program loader.

Parameters:
ADDR_W, 6, word-address width; DEPTH = 2**ADDR_W words
INSTR_W, 32, instruction word width
WAIT_STATES, 2, extra cycles between accept and response (0..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset (asserted when 0)
clk_en  in  1  global stall; when 0 all state and outputs hold
req_valid  in  1  fetch request
req_addr  in  ADDR_W  word address of requested instruction
req_ready  out  1  responder can accept a request this cycle
read_data  out  INSTR_W  fetched instruction, valid when data_ready=1
data_ready  out  1  one-cycle response strobe
wr_en  in  1  program-load write strobe
wr_addr  in  ADDR_W  write word address
wr_data  in  INSTR_W  write data

Behaviour:
- Reset (rst=0, async): state=IDLE, counter=0, read_data=0, data_ready=0, captured address=0. Array contents are not reset.
- States: IDLE, WAIT, RESP. PF is added only with the optional feature.
- All transitions and writes happen only on clk edges with clk_en=1. With clk_en=0, everything holds, including a high data_ready.
- req_ready is combinational: 1 in IDLE and RESP, 0 in WAIT.
- Accept = req_valid & req_ready & clk_en:
  - latch req_addr;
  - if WAIT_STATES=0, go to RESP;
  - otherwise load counter=WAIT_STATES-1 and go to WAIT.
- WAIT: counter decrements each enabled cycle. At counter=0, go to RESP. Requests are ignored and the initiator must hold req_valid/req_addr.
- On entry to RESP:
  - read_data is registered from array[latched addr];
  - data_ready=1 for exactly one enabled cycle.
- Latency: data_ready rises WAIT_STATES+1 enabled cycles after the accept edge.
- RESP exit:
  - with a new accept in the same cycle, follow the accept rules (back-to-back, no bubble);
  - otherwise go to IDLE, and data_ready falls.
- read_data holds its last value while data_ready=0.
- Writes: wr_en&clk_en writes array[wr_addr]. The write port is independent of the FSM.
- Write collision: if a write to the captured address lands on the same edge as the RESP capture, the read returns the OLD word (read-before-write). A write on any earlier edge is visible.
- Addresses wrap naturally; there is no out-of-range case.
- Reset mid-WAIT or mid-RESP aborts the transaction; no data_ready follows.

Optional Feature:
Macro: IMEM_PREFETCH_EN
- Defined:
  - after any RESP with no new accept, enter PF and fetch (captured addr+1) mod DEPTH into a prefetch register;
  - the fetch takes WAIT_STATES enabled cycles, then sets pf_valid;
  - req_ready=1 in PF and IDLE;
  - a request to pf_addr while pf_valid=1 goes straight to RESP (latency 1) using prefetched data;
  - a request to any other address aborts the prefetch, clears pf_valid, and takes the normal path;
  - a write to pf_addr clears pf_valid;
  - reset clears pf_valid.
- Undefined: no PF state or prefetch register; behaviour exactly as above.

Decomposition:
- Shared package fetch_pkg:
  - INSTR_W;
  - state enum (IDLE, WAIT, RESP, PF);
  - WAIT counter width constant (4 bits).
- One sub-module, imem_array: DEPTH x INSTR_W storage with one synchronous read port and one write port, read-before-write.
- FSM, counter and prefetch logic stay in imem_responder.

Test Plan:
- Reset, then write 0x20080005 to addr 3. Request addr 3 with WAIT_STATES=2: req_ready=0 for 2 cycles, data_ready=1 exactly 3 cycles after accept, read_data=0x20080005.
- WAIT_STATES=0, back-to-back requests to addrs 0,1,2 holding req_valid: data_ready high 3 consecutive cycles, correct words, no bubble.
- clk_en=0 for 4 cycles during WAIT: counter, req_ready and data_ready frozen. Response arrives 4 cycles later than nominal with identical data.
- Write 0xDEADBEEF to the in-flight addr on the RESP capture edge: response returns old word. A repeat request returns 0xDEADBEEF.
- Drive rst=0 asynchronously mid-WAIT: data_ready=0 and read_data=0 immediately. No response after release. Next request is served normally.
- With IMEM_PREFETCH_EN: request addr 63, wait WAIT_STATES+2 cycles, request addr 0 (wrap): data_ready 1 cycle after accept. A write to addr 0 before the request forces full latency.
